// File: rtl/hal_pkg.sv
// hal_pkg: shared constants, state type and byte-lane helper for HAL RAMs.
// No ports; imported by hal_sram_dp and hal_sram_dp_core.
package hal_pkg;

   localparam int COLL_OLD = 0;
   localparam int COLL_NEW = 1;

   localparam int HAL_RD_LAT_MIN = 1;
   localparam int HAL_RD_LAT_MAX = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } hal_st_e;

   function automatic logic [7:0] hal_lane_sel(
      input logic [7:0] i_old,
      input logic [7:0] i_new,
      input logic       i_sel
   );
      return i_sel ? i_new : i_old;
   endfunction

endpackage

// File: rtl/hal_sram_dp_core.sv
// hal_sram_dp_core: behavioural byte-masked dual-port array, registered reads.
// Ports: i_clk; per port i_re_*, i_we_* (high = write lane), i_addr_*, i_d_*, o_q_*.
module hal_sram_dp_core
   import hal_pkg::*;
#(
   parameter int DW = 128,
   parameter int AW = 12
) (
   input  logic            i_clk,
   input  logic            i_re_a,
   input  logic [DW/8-1:0] i_we_a,
   input  logic [AW-1:0]   i_addr_a,
   input  logic [DW-1:0]   i_d_a,
   output logic [DW-1:0]   o_q_a,
   input  logic            i_re_b,
   input  logic [DW/8-1:0] i_we_b,
   input  logic [AW-1:0]   i_addr_b,
   input  logic [DW-1:0]   i_d_b,
   output logic [DW-1:0]   o_q_b
);

   localparam int NB = DW / 8;

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_q_a;
   logic [DW-1:0] r_q_b;

   // Port B is applied last so it owns any lane both ports hit.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NB; i++) begin
         if (i_we_a[i]) r_mem[i_addr_a][8*i +: 8] <= i_d_a[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
         if (i_we_b[i]) r_mem[i_addr_b][8*i +: 8] <= i_d_b[8*i +: 8];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_re_a) r_q_a <= r_mem[i_addr_a];
      if (i_re_b) r_q_b <= r_mem[i_addr_b];
   end

   assign o_q_a = r_q_a;
   assign o_q_b = r_q_b;

endmodule

// File: rtl/hal_sram_dp.sv
// hal_sram_dp: true-dual-port byte-maskable SRAM with init clear and forwarding.
// Ports: CLK, RST, READY; per port CEN (low), WEN (low lanes), A, D in, Q out.
module hal_sram_dp
   import hal_pkg::*;
#(
   parameter int DW         = 128,
   parameter int AW         = 12,
   parameter int RD_LAT     = 1,
   parameter int INIT_CLEAR = 1,
   parameter int COLL_FWD   = 1
) (
   input  logic            CLK,
   input  logic            RST,
   output logic            READY,
   input  logic            CENA,
   input  logic [DW/8-1:0] WENA,
   input  logic [AW-1:0]   AA,
   input  logic [DW-1:0]   DA,
   output logic [DW-1:0]   QA,
   input  logic            CENB,
   input  logic [DW/8-1:0] WENB,
   input  logic [AW-1:0]   AB,
   input  logic [DW-1:0]   DB,
   output logic [DW-1:0]   QB
);

   localparam int NB = DW / 8;

   if (DW % 8 != 0) begin : g_bad_dw
      $error("hal_sram_dp: DW must be a multiple of 8");
   end
   if (RD_LAT < HAL_RD_LAT_MIN || RD_LAT > HAL_RD_LAT_MAX) begin : g_bad_lat
      $error("hal_sram_dp: RD_LAT must be 1 or 2");
   end

   function automatic logic [DW-1:0] f_merge(
      input logic [DW-1:0] i_old,
      input logic [DW-1:0] i_new,
      input logic [NB-1:0] i_m
   );
      logic [DW-1:0] v;
      v = i_old;
      for (int i = 0; i < NB; i++) begin
         v[8*i +: 8] = hal_lane_sel(i_old[8*i +: 8], i_new[8*i +: 8], i_m[i]);
      end
      return v;
   endfunction

   hal_st_e       r_state;
   hal_st_e       w_state_nxt;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_nxt;
   logic          w_init_we;
   logic          r_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_init_we   = 1'b0;
      if (RST) begin
         w_state_nxt = ST_INIT;
         w_cnt_nxt   = '0;
      end else if (r_state == ST_INIT) begin
         if (INIT_CLEAR == 0) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_init_we = 1'b1;
            w_cnt_nxt = r_cnt + AW'(1);
            if (r_cnt == '1) w_state_nxt = ST_RUN;
         end
      end
   end

   // With clearing, READY follows the last clear write by one cycle;
   // without it, READY rises on the first cycle out of reset.
   always_ff @(posedge CLK) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (RST) r_ready <= 1'b0;
      else if (INIT_CLEAR != 0) r_ready <= (r_state == ST_RUN);
      else r_ready <= (w_state_nxt == ST_RUN);
   end

   assign READY = r_ready;

   logic          w_acta;
   logic          w_actb;
   logic [NB-1:0] w_wea;
   logic [NB-1:0] w_web;
   logic          w_same;
   logic [NB-1:0] w_xa;
   logic [NB-1:0] w_xb;

   assign w_acta = ~CENA & r_ready & ~RST;
   assign w_actb = ~CENB & r_ready & ~RST;
   assign w_wea  = w_acta ? ~WENA : '0;
   assign w_web  = w_actb ? ~WENB : '0;
   assign w_same = (AA == AB);

   // Lanes of the other port's write that a reader must see. A writing
   // reader always sees the final word; otherwise only when forwarding.
   assign w_xb = (w_actb && w_same &&
                  (COLL_FWD == COLL_NEW || |w_wea)) ? w_web : '0;
   assign w_xa = (w_acta && w_same &&
                  (COLL_FWD == COLL_NEW || |w_web)) ? w_wea : '0;

   logic [NB-1:0] w_core_wea;
   logic [AW-1:0] w_core_aa;
   logic [DW-1:0] w_core_da;
   logic [DW-1:0] w_core_qa;
   logic [DW-1:0] w_core_qb;

   assign w_core_wea = w_init_we ? '1 :
                       (w_wea & ~(w_same ? w_web : '0));
   assign w_core_aa  = w_init_we ? r_cnt : AA;
   assign w_core_da  = w_init_we ? '0 : DA;

   hal_sram_dp_core #(
      .DW (DW),
      .AW (AW)
   ) u_core (
      .i_clk    (CLK),
      .i_re_a   (w_acta),
      .i_we_a   (w_core_wea),
      .i_addr_a (w_core_aa),
      .i_d_a    (w_core_da),
      .o_q_a    (w_core_qa),
      .i_re_b   (w_actb),
      .i_we_b   (w_web),
      .i_addr_b (AB),
      .i_d_b    (DB),
      .o_q_b    (w_core_qb)
   );

   // The core returns the pre-write word; these registers carry the
   // lanes that must be overlaid on it, and hold while a port is idle.
   logic          r_va;
   logic          r_vb;
   logic [NB-1:0] r_fa_m;
   logic [NB-1:0] r_fb_m;
   logic [DW-1:0] r_fa_d;
   logic [DW-1:0] r_fb_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_va   <= 1'b0;
         r_vb   <= 1'b0;
         r_fa_m <= '0;
         r_fb_m <= '0;
         r_fa_d <= '0;
         r_fb_d <= '0;
      end else begin
         if (w_acta) begin
            r_va   <= 1'b1;
            r_fa_m <= w_wea | w_xb;
            r_fa_d <= f_merge(DA, DB, w_xb);
         end
         if (w_actb) begin
            r_vb   <= 1'b1;
            r_fb_m <= w_web | w_xa;
            r_fb_d <= f_merge(DA, DB, w_web);
         end
      end
   end

   logic [DW-1:0] w_qa1;
   logic [DW-1:0] w_qb1;

   assign w_qa1 = r_va ? f_merge(w_core_qa, r_fa_d, r_fa_m) : '0;
   assign w_qb1 = r_vb ? f_merge(w_core_qb, r_fb_d, r_fb_m) : '0;

   if (RD_LAT == 2) begin : g_lat2
      logic          r_rda;
      logic          r_rdb;
      logic [DW-1:0] r_qa2;
      logic [DW-1:0] r_qb2;

      always_ff @(posedge CLK) begin
         if (RST) begin
            r_rda <= 1'b0;
            r_rdb <= 1'b0;
            r_qa2 <= '0;
            r_qb2 <= '0;
         end else begin
            r_rda <= w_acta;
            r_rdb <= w_actb;
            if (r_rda) r_qa2 <= w_qa1;
            if (r_rdb) r_qb2 <= w_qb1;
         end
      end

      assign QA = r_qa2;
      assign QB = r_qb2;
   end else begin : g_lat1
      assign QA = w_qa1;
      assign QB = w_qb1;
   end

endmodule
